// File: rtl/scene_pkg.sv
// rtl/scene_pkg.sv - scene frame constants, FSM states and record field offsets
package scene_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        BODY,
        CHECK,
        COMMIT
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Bytes in one sprite record: locations, velocities, mass, radius.
    function automatic int rec_bytes(input int width, input int dims);
        return 2 * dims * (width / 8) + width / 16 + 1;
    endfunction

    // Byte offset of location word d inside a record.
    function automatic int loc_off(input int width, input int d);
        return d * (width / 8);
    endfunction

    // Byte offset of velocity word d inside a record.
    function automatic int velo_off(input int width, input int dims, input int d);
        return (dims + d) * (width / 8);
    endfunction

    // Byte offset of the mass field inside a record.
    function automatic int mass_off(input int width, input int dims);
        return 2 * dims * (width / 8);
    endfunction

    // Byte offset of the radius byte inside a record.
    function automatic int rad_off(input int width, input int dims);
        return mass_off(width, dims) + width / 16;
    endfunction

endpackage

// File: rtl/scene_watchdog.sv
// rtl/scene_watchdog.sv - idle-cycle counter that flags a stalled frame
module scene_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic xfer_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Fires on the TIMEOUT_CYC-th consecutive idle cycle while a frame is open.
    assign expired_o = active_i && !xfer_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Count idle cycles; any transfer or leaving the frame restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || xfer_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scene_loader.sv
// rtl/scene_loader.sv - framed scene byte-stream unpacker (optional stall timeout: SCENE_LOADER_TIMEOUT_EN)
module scene_loader
    import scene_pkg::*;
#(
    parameter int SPRITES     = 9,
    parameter int WIDTH       = 32,
    parameter int DIMENSIONS  = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                               clk_162,
    input  logic                               rst,
    input  logic [7:0]                         in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_locations,
    output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_velos,
    output logic [SPRITES*WIDTH/2-1:0]          masses,
    output logic [SPRITES*7-1:0]                radii,
    output logic                               data_ready,
    output logic                               frame_err,
    output logic                               busy
);

    localparam int REC_B  = rec_bytes(WIDTH, DIMENSIONS);
    localparam int WB     = WIDTH / 8;
    localparam int MB     = WIDTH / 16;
    localparam int SIDX_W = (SPRITES > 1) ? $clog2(SPRITES) : 1;
    localparam int BIDX_W = $clog2(REC_B);
    localparam int LW     = SPRITES * DIMENSIONS * WIDTH;
    localparam int MW     = SPRITES * WIDTH / 2;
    localparam int RW     = SPRITES * 7;

    state_t              state_q;
    logic [SIDX_W-1:0]   sprite_idx_q;
    logic [SIDX_W-1:0]   last_sprite_q;
    logic [BIDX_W-1:0]   byte_idx_q;
    logic [7:0]          csum_q;
    logic [7:0]          shadow_q [SPRITES][REC_B];
    logic [LW-1:0]       locs_q;
    logic [LW-1:0]       velos_q;
    logic [MW-1:0]       masses_q;
    logic [RW-1:0]       radii_q;
    logic                data_ready_q;
    logic                frame_err_q;
    logic                busy_q;

    logic [LW-1:0]       dec_loc;
    logic [LW-1:0]       dec_velo;
    logic [MW-1:0]       dec_mass;
    logic [RW-1:0]       dec_rad;
    logic                xfer;
    logic                wd_expired;

    assign in_ready       = (state_q != COMMIT);
    assign xfer           = in_valid && in_ready;
    assign init_locations = locs_q;
    assign init_velos     = velos_q;
    assign masses         = masses_q;
    assign radii          = radii_q;
    assign data_ready     = data_ready_q;
    assign frame_err      = frame_err_q;
    assign busy           = busy_q;

`ifdef SCENE_LOADER_TIMEOUT_EN
    logic wd_active;
    assign wd_active = (state_q == COUNT) || (state_q == BODY) || (state_q == CHECK);

    scene_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (clk_162),
        .rst_i    (rst),
        .active_i (wd_active),
        .xfer_i   (xfer),
        .expired_o(wd_expired)
    );
`else
    // Without the timeout a stalled frame waits forever; this never fires.
    assign wd_expired = (TIMEOUT_CYC < 0);
`endif

    // Reassemble the shadow record bytes (MSB first) into the output layouts.
    always_comb begin
        dec_loc  = '0;
        dec_velo = '0;
        dec_mass = '0;
        dec_rad  = '0;
        for (int s = 0; s < SPRITES; s++) begin
            for (int d = 0; d < DIMENSIONS; d++) begin
                for (int b = 0; b < WB; b++) begin
                    dec_loc[(s*DIMENSIONS+d)*WIDTH + WIDTH - 1 - 8*b -: 8] =
                        shadow_q[s][loc_off(WIDTH, d) + b];
                    dec_velo[(s*DIMENSIONS+d)*WIDTH + WIDTH - 1 - 8*b -: 8] =
                        shadow_q[s][velo_off(WIDTH, DIMENSIONS, d) + b];
                end
            end
            for (int b = 0; b < MB; b++) begin
                dec_mass[s*(WIDTH/2) + WIDTH/2 - 1 - 8*b -: 8] =
                    shadow_q[s][mass_off(WIDTH, DIMENSIONS) + b];
            end
            dec_rad[s*7 +: 7] = shadow_q[s][rad_off(WIDTH, DIMENSIONS)][6:0];
        end
    end

    // Frame FSM: sync, count, record body, checksum, then a one-cycle commit.
    always_ff @(posedge clk_162) begin
        if (rst) begin
            state_q       <= IDLE;
            sprite_idx_q  <= '0;
            last_sprite_q <= '0;
            byte_idx_q    <= '0;
            csum_q        <= '0;
            locs_q        <= '0;
            velos_q       <= '0;
            masses_q      <= '0;
            radii_q       <= '0;
            data_ready_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            for (int s = 0; s < SPRITES; s++) begin
                for (int b = 0; b < REC_B; b++) begin
                    shadow_q[s][b] <= '0;
                end
            end
        end else begin
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (xfer && (in_data == SYNC_BYTE)) begin
                        busy_q  <= 1'b1;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (wd_expired) begin
                        frame_err_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (xfer) begin
                        if ((in_data == 8'd0) || (in_data > 8'(SPRITES))) begin
                            frame_err_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            last_sprite_q <= SIDX_W'(in_data - 8'd1);
                            csum_q        <= in_data;
                            sprite_idx_q  <= '0;
                            byte_idx_q    <= '0;
                            for (int s = 0; s < SPRITES; s++) begin
                                for (int b = 0; b < REC_B; b++) begin
                                    shadow_q[s][b] <= '0;
                                end
                            end
                            state_q <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (wd_expired) begin
                        frame_err_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (xfer) begin
                        shadow_q[sprite_idx_q][byte_idx_q] <= in_data;
                        csum_q <= csum_q ^ in_data;
                        if (byte_idx_q == BIDX_W'(REC_B - 1)) begin
                            byte_idx_q <= '0;
                            if (sprite_idx_q == last_sprite_q) begin
                                state_q <= CHECK;
                            end else begin
                                sprite_idx_q <= sprite_idx_q + SIDX_W'(1);
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + BIDX_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (wd_expired) begin
                        frame_err_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (xfer) begin
                        busy_q <= 1'b0;
                        if (in_data == csum_q) begin
                            locs_q       <= dec_loc;
                            velos_q      <= dec_velo;
                            masses_q     <= dec_mass;
                            radii_q      <= dec_rad;
                            data_ready_q <= 1'b1;
                            state_q      <= COMMIT;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
